// File: rtl/irq_ctrl_mem_pkg.sv
// Shared register map and helpers for the memory-mapped interrupt aggregator.
package irq_ctrl_mem_pkg;

    localparam int REG_W = 8;

    localparam logic [7:0] IRQ_IEN_ADDR     = 8'h00;
    localparam logic [7:0] IRQ_PENDING_ADDR = 8'h01;
    localparam logic [7:0] IRQ_MODE_ADDR    = 8'h02;
    localparam logic [7:0] IRQ_CAUSE_ADDR   = 8'h03;
    localparam logic [7:0] IRQ_MASTER_ADDR  = 8'h04;

    localparam int IRQ_CAUSE_VALID_BIT = 7;

    // CAUSE reads as all-zero when nothing is pending and enabled.
    function automatic logic [REG_W-1:0] cause_byte(input logic valid, input logic [2:0] idx);
        logic [REG_W-1:0] b;
        b = '0;
        if (valid) begin
            b[IRQ_CAUSE_VALID_BIT] = 1'b1;
            b[2:0]                 = idx;
        end
        return b;
    endfunction

endpackage

// File: rtl/irq_ctrl_mem_prio_enc.sv
// Lowest-index-wins priority encoder for up to eight interrupt sources.
module irq_prio_enc #(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] i_vec,
    output logic               o_valid,
    output logic [2:0]         o_idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_valid = 1'b1;
                o_idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl_mem.sv
// Interrupt aggregator: latches peripheral irq lines as pending, masks them and drives one CPU irq.
module irq_ctrl_mem
    import irq_ctrl_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IRQ    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    bus_err,
    input  logic [NUM_IRQ-1:0]      irq_in,
    output logic                    cpu_irq
);

    typedef enum logic {ST_ISSUE, ST_RETIRE} state_t;

    state_t             r_state;
    logic               r_ready;
    logic               r_error;
    logic [REG_W-1:0]   r_rdata;
    logic [NUM_IRQ-1:0] r_ien;
    logic [NUM_IRQ-1:0] r_mode;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_prev_irq;
    logic               r_master;

    logic               w_issue;
    logic               w_addr_ok;
    logic [REG_W-1:0]   w_rd_byte;
    logic [NUM_IRQ-1:0] w_wdata;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_pend_nxt;
    logic               w_cause_vld;
    logic [2:0]         w_cause_idx;
    logic               w_unused;

    assign w_unused = ^{i_data, be};

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
        .i_vec   (r_pending & r_ien),
        .o_valid (w_cause_vld),
        .o_idx   (w_cause_idx)
    );

    assign w_issue = be[0] & enable & ~r_error & ~r_ready & (r_state == ST_ISSUE);
    assign w_wdata = i_data[NUM_IRQ-1:0];

    always_comb begin
        w_addr_ok = 1'b1;
        w_rd_byte = '0;
        case (addr)
            ADDR_WIDTH'(IRQ_IEN_ADDR):     w_rd_byte = REG_W'(r_ien);
            ADDR_WIDTH'(IRQ_PENDING_ADDR): w_rd_byte = REG_W'(r_pending);
            ADDR_WIDTH'(IRQ_MODE_ADDR):    w_rd_byte = REG_W'(r_mode);
            ADDR_WIDTH'(IRQ_CAUSE_ADDR):   w_rd_byte = cause_byte(w_cause_vld, w_cause_idx);
            ADDR_WIDTH'(IRQ_MASTER_ADDR):  w_rd_byte = REG_W'(r_master);
            default:                       w_addr_ok = 1'b0;
        endcase
    end

    // W1C only reaches edge-mode bits; a rising edge in the same cycle wins over the clear.
    assign w_w1c = (w_issue && wr_en && addr == ADDR_WIDTH'(IRQ_PENDING_ADDR))
                 ? (w_wdata & r_mode) : '0;
    assign w_rise     = irq_in & ~r_prev_irq;
    assign w_pend_nxt = (r_mode & ((r_pending & ~w_w1c) | w_rise)) | (~r_mode & irq_in);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_prev_irq <= '0;
        end else begin
            r_pending  <= w_pend_nxt;
            r_prev_irq <= irq_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_ISSUE;
            r_ready  <= 1'b0;
            r_error  <= 1'b0;
            r_rdata  <= '0;
            r_ien    <= '0;
            r_mode   <= '0;
            r_master <= 1'b0;
        end else if (!be[0]) begin
            r_ready <= 1'b1;
            r_error <= 1'b1;
        end else if (!enable) begin
            r_ready <= 1'b0;
            r_error <= 1'b0;
            r_state <= ST_ISSUE;
        end else if (!r_error && !r_ready) begin
            case (r_state)
                ST_ISSUE: begin
                    if (!w_addr_ok) begin
                        r_ready <= 1'b1;
                        r_error <= 1'b1;
                    end else begin
                        r_state <= ST_RETIRE;
                        if (wr_en) begin
                            case (addr)
                                ADDR_WIDTH'(IRQ_IEN_ADDR):    r_ien    <= w_wdata;
                                ADDR_WIDTH'(IRQ_MODE_ADDR):   r_mode   <= w_wdata;
                                ADDR_WIDTH'(IRQ_MASTER_ADDR): r_master <= i_data[0];
                                default: ;
                            endcase
                        end else begin
                            r_rdata <= w_rd_byte;
                        end
                    end
                end
                ST_RETIRE: r_ready <= 1'b1;
                default:   r_state <= ST_ISSUE;
            endcase
        end
    end

    assign ready   = r_ready;
    assign o_data  = DATA_WIDTH'(r_rdata);
    assign bus_err = r_error & rst_n;
    assign cpu_irq = r_master & w_cause_vld;

endmodule
